// File: rtl/cnn_seq_pkg.sv
// Shared definitions for the CNN training-step sequencer.
// Configuration macro: BACKWARD_PASS_EN adds the backward stages and the
// once-per-batch weight update (8 engines). Without it, only the forward
// and loss stages are sequenced (4 engines).
package cnn_seq_pkg;

  localparam int STG_CONV_F = 0;
  localparam int STG_POOL_F = 1;
  localparam int STG_FC_F   = 2;
  localparam int STG_LOSS   = 3;
  localparam int STG_FC_B   = 4;
  localparam int STG_POOL_B = 5;
  localparam int STG_CONV_B = 6;
  localparam int STG_UPDATE = 7;

`ifdef BACKWARD_PASS_EN
  localparam int NSTG            = 8;
  localparam int LAST_SAMPLE_STG = STG_CONV_B;
`else
  localparam int NSTG            = 4;
  localparam int LAST_SAMPLE_STG = STG_LOSS;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SAMPLE,
    S_ISSUE,
    S_WAIT,
    S_ADVANCE,
    S_FINISH_UPD,
    S_FINISH,
    S_ERROR
  } seq_state_t;

  // One-hot engine select for a 3-bit stage index; indices beyond NSTG give 0.
  function automatic logic [NSTG-1:0] stage_onehot(input logic [2:0] stg);
    logic [NSTG-1:0] oh;
    for (int i = 0; i < NSTG; i++) begin
      oh[i] = (stg == 3'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/train_step_sequencer_if.sv
// Engine and sample-source handshake bundle for the training-step sequencer.
// master: the sequencer side; slave: the engines / sample source side.
interface train_step_sequencer_if #(
  parameter int LOSS_W = 32
);
  import cnn_seq_pkg::*;

  logic              sample_valid;
  logic              sample_ack;
  logic [NSTG-1:0]   stage_start;
  logic [NSTG-1:0]   stage_done;
  logic [LOSS_W-1:0] loss_in;

  modport master (
    input  sample_valid,
    input  stage_done,
    input  loss_in,
    output sample_ack,
    output stage_start
  );

  modport slave (
    output sample_valid,
    output stage_done,
    output loss_in,
    input  sample_ack,
    input  stage_start
  );

endinterface

// File: rtl/stage_watchdog.sv
// Per-stage timeout counter. Cleared while a stage is being issued and
// counts the cycles spent waiting for that stage's done. expired is raised
// during the TIMEOUT_CYCLES-th waiting cycle, i.e. the cycle whose
// increment would bring the count to TIMEOUT_CYCLES.
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] count;

  assign expired = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count waiting cycles; hold once expired so the count never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/train_step_sequencer.sv
// Top-level scheduler for one CNN training batch: pulses each stage engine
// in order, waits for its done, accumulates the per-sample loss with
// saturation and trips to ERROR on a stage timeout or a done from the
// wrong engine.
// Configuration macro: BACKWARD_PASS_EN (backward stages per sample plus a
// single update stage issued from FINISH_UPD after the last sample).
module train_step_sequencer
  import cnn_seq_pkg::*;
#(
  parameter  int BATCH_SIZE     = 16,
  parameter  int TIMEOUT_CYCLES = 65535,
  parameter  int LOSS_W         = 32,
  localparam int IDX_W          = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  train_step_sequencer_if.master eng,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_stage,
  output logic [2:0]            cur_stage,
  output logic [IDX_W-1:0]      sample_idx,
  output logic [LOSS_W-1:0]     batch_loss
);

  seq_state_t      state;
  logic [NSTG-1:0] cur_onehot;
  logic            expected_done;
  logic            spurious_done;
  logic            wd_expired;
  logic [LOSS_W:0] loss_sum;

  assign cur_onehot    = stage_onehot(cur_stage);
  assign expected_done = |(eng.stage_done & cur_onehot);
  assign spurious_done = |(eng.stage_done & ~cur_onehot);
  assign loss_sum      = {1'b0, batch_loss} + {1'b0, eng.loss_in};

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == S_ISSUE),
    .en     (state == S_WAIT),
    .expired(wd_expired)
  );

  // Batch FSM; every output is registered and set on entry to the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_stage       <= '0;
      cur_stage       <= '0;
      sample_idx      <= '0;
      batch_loss      <= '0;
      eng.stage_start <= '0;
      eng.sample_ack  <= 1'b0;
    end else begin
      eng.stage_start <= '0;
      eng.sample_ack  <= 1'b0;
      done            <= 1'b0;
      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_ERROR: begin
            if (start) begin
              state      <= S_WAIT_SAMPLE;
              busy       <= 1'b1;
              error      <= 1'b0;
              batch_loss <= '0;
              sample_idx <= '0;
            end
          end
          S_WAIT_SAMPLE: begin
            if (eng.sample_valid) begin
              cur_stage       <= 3'(STG_CONV_F);
              eng.stage_start <= stage_onehot(3'(STG_CONV_F));
              state           <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (spurious_done || (!expected_done && wd_expired)) begin
              state     <= S_ERROR;
              busy      <= 1'b0;
              error     <= 1'b1;
              err_stage <= cur_stage;
            end else if (expected_done) begin
              state <= S_ADVANCE;
              if (cur_stage == 3'(STG_LOSS)) begin
                batch_loss <= loss_sum[LOSS_W] ? {LOSS_W{1'b1}} : loss_sum[LOSS_W-1:0];
              end
              if (cur_stage == 3'(LAST_SAMPLE_STG)) begin
                eng.sample_ack <= 1'b1;
              end
            end
          end
          S_ADVANCE: begin
            if (cur_stage == 3'(LAST_SAMPLE_STG)) begin
              if (sample_idx == IDX_W'(BATCH_SIZE - 1)) begin
                sample_idx <= '0;
`ifdef BACKWARD_PASS_EN
                state      <= S_FINISH_UPD;
`else
                state      <= S_FINISH;
                done       <= 1'b1;
                busy       <= 1'b0;
`endif
              end else begin
                sample_idx <= sample_idx + 1'b1;
                state      <= S_WAIT_SAMPLE;
              end
`ifdef BACKWARD_PASS_EN
            end else if (cur_stage == 3'(STG_UPDATE)) begin
              state <= S_FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
`endif
            end else begin
              cur_stage       <= cur_stage + 3'd1;
              eng.stage_start <= stage_onehot(cur_stage + 3'd1);
              state           <= S_ISSUE;
            end
          end
`ifdef BACKWARD_PASS_EN
          S_FINISH_UPD: begin
            cur_stage       <= 3'(STG_UPDATE);
            eng.stage_start <= stage_onehot(3'(STG_UPDATE));
            state           <= S_ISSUE;
          end
`endif
          S_FINISH: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_train_step_sequencer.sv
// Self-checking bench for train_step_sequencer. Expected stage-start order
// and batch losses are queued when a batch is launched and checked as the
// sequencer pulses its engines and finishes. Honors BACKWARD_PASS_EN.
module tb_train_step_sequencer;
  import cnn_seq_pkg::*;

`ifdef BACKWARD_PASS_EN
  localparam int TB_BATCH    = 3;
  localparam int TB_LAST_SMP = 6;
`else
  localparam int TB_BATCH    = 2;
  localparam int TB_LAST_SMP = 3;
`endif
  localparam int TB_TIMEOUT   = 20;
  localparam int TB_LOSS_W    = 32;
  localparam int TB_IDX_W     = (TB_BATCH > 1) ? $clog2(TB_BATCH) : 1;
  localparam int ENGINE_DELAY = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [2:0]           err_stage;
  logic [2:0]           cur_stage;
  logic [TB_IDX_W-1:0]  sample_idx;
  logic [TB_LOSS_W-1:0] batch_loss;

  train_step_sequencer_if #(.LOSS_W(TB_LOSS_W)) eng ();

  train_step_sequencer #(
    .BATCH_SIZE    (TB_BATCH),
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .LOSS_W        (TB_LOSS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .eng       (eng),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_stage (err_stage),
    .cur_stage (cur_stage),
    .sample_idx(sample_idx),
    .batch_loss(batch_loss)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          exp_q[$];
  logic [31:0] loss_q[$];
  logic [31:0] exp_loss_q[$];
  int          ack_count  = 0;
  int          done_count = 0;
  int          ack_base;
  int          done_base;
  int          exp_stage;

  bit              engine_en   = 1'b1;
  int              stall_stage = -1;
  int              stall_skip  = 0;
  logic [NSTG-1:0] manual_done = '0;
  logic [NSTG-1:0] next_done;
  int              pend_cnt    = 0;
  int              pend_stg    = 0;
  int              eng_stg;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int onehot_index(input logic [NSTG-1:0] v);
    int idx;
    idx = -1;
    for (int i = 0; i < NSTG; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Scoreboard: every start pulse must match the next queued stage index.
  always @(negedge clk) begin
    if (eng.stage_start != '0) begin
      checkOutput("start_onehot", 64'($onehot(eng.stage_start)), 1);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_start", 64'(eng.stage_start), 0);
      end else begin
        exp_stage = exp_q.pop_front();
        checkOutput("stage_order", 64'(onehot_index(eng.stage_start)), 64'(exp_stage));
      end
    end
    if (eng.sample_ack === 1'b1) ack_count++;
    if (done === 1'b1) done_count++;
  end

  // Engine model: answers each start ENGINE_DELAY cycles later, supplies loss with the loss stage.
  initial begin : engine_model
    eng.stage_done = '0;
    eng.loss_in    = '0;
    forever begin
      @(negedge clk);
      next_done = '0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          next_done[pend_stg] = 1'b1;
          if (pend_stg == STG_LOSS) begin
            if (loss_q.size() > 0) eng.loss_in = loss_q.pop_front();
            else eng.loss_in = '0;
          end
        end
      end
      if (engine_en && eng.stage_start != '0) begin
        eng_stg = onehot_index(eng.stage_start);
        if (eng_stg != stall_stage || stall_skip > 0) begin
          if (eng_stg == stall_stage) stall_skip--;
          pend_stg = eng_stg;
          pend_cnt = ENGINE_DELAY;
        end
      end
      eng.stage_done = next_done | manual_done;
    end
  end

  task automatic pulseStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pushSampleStages(input int last_stage);
    for (int g = 0; g <= last_stage; g++) exp_q.push_back(g);
  endtask

  // Queue a full batch's expected starts and saturated loss, then launch it.
  task automatic applyStimulus(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2);
    logic [32:0] acc;
    logic [31:0] lv;
    acc = '0;
    exp_q.delete();
    loss_q.delete();
    for (int s = 0; s < TB_BATCH; s++) begin
      pushSampleStages(TB_LAST_SMP);
      lv = (s == 0) ? l0 : ((s == 1) ? l1 : l2);
      loss_q.push_back(lv);
      acc = acc + {1'b0, lv};
      if (acc[32]) acc = 33'h0_FFFF_FFFF;
    end
`ifdef BACKWARD_PASS_EN
    exp_q.push_back(STG_UPDATE);
`endif
    exp_loss_q.push_back(acc[31:0]);
    ack_base  = ack_count;
    done_base = done_count;
    pulseStart();
  endtask

  task automatic checkBatchEnd(input string tag);
    bit          got;
    logic [31:0] exp_l;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, 64'(got), 1);
    if (got) begin
      exp_l = exp_loss_q.pop_front();
      checkOutput({tag, "_batch_loss"}, 64'(batch_loss), 64'(exp_l));
      checkOutput({tag, "_busy_at_done"}, 64'(busy), 0);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_sample_acks"}, 64'(ack_count - ack_base), 64'(TB_BATCH));
    checkOutput({tag, "_done_pulses"}, 64'(done_count - done_base), 1);
    checkOutput({tag, "_starts_left"}, 64'(exp_q.size()), 0);
    checkOutput({tag, "_error"}, 64'(error), 0);
  endtask

  task automatic waitStageStart(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (eng.stage_start != '0) seen = 1'b1;
    end
  endtask

  initial begin : global_limit
    #1_000_000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main_seq
    bit got;
    int t_start;
    int t_err;

    rst              = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    eng.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst              = 1'b0;
    eng.sample_valid = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
    checkOutput("rst_error", 64'(error), 0);
    checkOutput("rst_err_stage", 64'(err_stage), 0);
    checkOutput("rst_cur_stage", 64'(cur_stage), 0);
    checkOutput("rst_sample_idx", 64'(sample_idx), 0);
    checkOutput("rst_batch_loss", 64'(batch_loss), 0);
    checkOutput("rst_stage_start", 64'(eng.stage_start), 0);
    checkOutput("rst_sample_ack", 64'(eng.sample_ack), 0);

    // Normal batch with ordinary losses
    $display("[TB] normal batch");
    applyStimulus(32'd100, 32'd200, 32'd300);
    checkOutput("b1_busy_after_start", 64'(busy), 1);
    checkBatchEnd("b1");

    // Saturating loss accumulation
    $display("[TB] saturating batch");
    applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
    checkBatchEnd("b2");

    // fc-fwd stalls on the second sample -> watchdog error
    $display("[TB] watchdog timeout");
    exp_q.delete();
    loss_q.delete();
    pushSampleStages(TB_LAST_SMP);
    pushSampleStages(STG_FC_F);
    loss_q.push_back(32'd55);
    stall_stage = STG_FC_F;
    stall_skip  = 1;
    done_base   = done_count;
    pulseStart();
    got     = 1'b0;
    t_start = -1000;
    t_err   = 0;
    for (int c = 0; c < 800 && !got; c++) begin
      @(negedge clk);
      if (eng.stage_start[STG_FC_F] === 1'b1) t_start = c;
      if (error === 1'b1) begin
        got   = 1'b1;
        t_err = c;
      end
    end
    checkOutput("tmo_error_seen", 64'(got), 1);
    checkOutput("tmo_latency", 64'(t_err - t_start), 64'(TB_TIMEOUT + 1));
    checkOutput("tmo_err_stage", 64'(err_stage), 64'(STG_FC_F));
    checkOutput("tmo_busy", 64'(busy), 0);
    checkOutput("tmo_sample_idx", 64'(sample_idx), 1);
    repeat (5) @(negedge clk);
    checkOutput("tmo_error_sticky", 64'(error), 1);
    checkOutput("tmo_no_done", 64'(done_count - done_base), 0);
    checkOutput("tmo_starts_left", 64'(exp_q.size()), 0);

    // Restart from ERROR
    stall_stage = -1;
    applyStimulus(32'd7, 32'd8, 32'd9);
    checkOutput("restart_error_clr", 64'(error), 0);
    checkOutput("restart_sample_idx", 64'(sample_idx), 0);
    checkOutput("restart_busy", 64'(busy), 1);
    checkBatchEnd("b3");

    // Spurious done from the wrong engine while awaiting stage 0
    $display("[TB] spurious done");
    engine_en = 1'b0;
    exp_q.delete();
    exp_q.push_back(STG_CONV_F);
    pulseStart();
    waitStageStart(got);
    checkOutput("spur_start_seen", 64'(got), 1);
    @(posedge clk); #1;
    manual_done = '0;
    manual_done[STG_POOL_F] = 1'b1;
    @(posedge clk); #1;
    manual_done = '0;
    @(negedge clk);
    checkOutput("spur_error", 64'(error), 1);
    checkOutput("spur_err_stage", 64'(err_stage), 64'(STG_CONV_F));
    checkOutput("spur_busy", 64'(busy), 0);

    // Abort in the same cycle as the awaited done
    $display("[TB] abort");
    exp_q.delete();
    exp_q.push_back(STG_CONV_F);
    done_base = done_count;
    pulseStart();
    checkOutput("abort_start_clears_error", 64'(error), 0);
    waitStageStart(got);
    checkOutput("abort_start_seen", 64'(got), 1);
    @(posedge clk); #1;
    manual_done = '0;
    manual_done[STG_CONV_F] = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    manual_done = '0;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", 64'(busy), 0);
    repeat (20) @(negedge clk);
    checkOutput("abort_no_done", 64'(done_count - done_base), 0);
    checkOutput("abort_loss_held", 64'(batch_loss), 0);
    checkOutput("abort_error_unchanged", 64'(error), 0);
    checkOutput("abort_starts_left", 64'(exp_q.size()), 0);

    // Reset in the middle of a batch
    $display("[TB] mid-batch reset");
    engine_en = 1'b1;
    applyStimulus(32'd100, 32'd200, 32'd300);
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (ack_count != ack_base) got = 1'b1;
    end
    checkOutput("mrst_first_ack", 64'(got), 1);
    checkOutput("mrst_loss_before", 64'(batch_loss), 100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    loss_q.delete();
    exp_loss_q.delete();
    @(negedge clk);
    checkOutput("mrst_busy", 64'(busy), 0);
    checkOutput("mrst_cur_stage", 64'(cur_stage), 0);
    checkOutput("mrst_sample_idx", 64'(sample_idx), 0);
    checkOutput("mrst_batch_loss", 64'(batch_loss), 0);
    checkOutput("mrst_stage_start", 64'(eng.stage_start), 0);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
